// File: rtl/switch_pio_pkg.sv
// Shared constants for the debounced switch PIO: register map and edge-type encodings.
package switch_pio_pkg;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Mask of the implemented low bits of a 32-bit bus word.
  function automatic logic [31:0] width_mask(input int w);
    width_mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/pio_debounce_bit.sv
// One input line: multi-flop synchroniser followed by a stable-count debouncer.
module pio_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic stable_o
);
  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   stable_q;
  logic                   synced;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign stable_o = stable_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
      if (DEBOUNCE_CYCLES == 0) begin
        stable_q <= synced;
        cnt_q    <= '0;
      end else if (synced == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        // Last of DEBOUNCE_CYCLES consecutive mismatching cycles: accept the new level.
        stable_q <= synced;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
endmodule

// File: rtl/switch_pio_debounced.sv
// Avalon-MM switch PIO: per-bit debounced inputs, edge capture (W1C), masked level IRQ.
module switch_pio_debounced
  import switch_pio_pkg::*;
#(
  parameter int WIDTH           = 18,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam logic [31:0] VMASK = width_mask(WIDTH);

  logic [WIDTH-1:0] stable, stable_d_q, edge_hit;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      irqmask_q, irqmask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q;
  logic             wr;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_bit
      pio_debounce_bit #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
        .clk     (clk),
        .reset_n (reset_n),
        .in_i    (in_port[g]),
        .stable_o(stable[g])
      );
    end
  endgenerate

  assign wr       = chipselect & ~write_n;
  assign readdata = readdata_q;
  assign irq      = irq_q;

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_hit = ~stable & stable_d_q;
      EDGE_ANY:  edge_hit = stable ^ stable_d_q;
      default:   edge_hit = stable & ~stable_d_q;
    endcase
  end

  always_comb begin
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr && address == ADDR_IRQMASK) irqmask_d = writedata & VMASK;
    if (wr && address == ADDR_EDGECAP) edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    // A new edge in the same cycle as its clear keeps the bit set.
    edgecap_d = edgecap_d | edge_hit;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = stable;
      ADDR_IRQMASK: readdata_d            = irqmask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:      readdata_d            = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable_d_q <= '0;
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      stable_d_q <= stable;
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
      irq_q      <= |(edgecap_q & irqmask_q[WIDTH-1:0]);
    end
  end
endmodule

// File: tb/tb_switch_pio_debounced.sv
// Directed bench: main instance (rising, debounce 4) plus falling, any-edge and no-debounce instances.
module tb_switch_pio_debounced;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata;
  logic [17:0] in_m, in_f, in_a, in_z;
  logic [31:0] rd_m, rd_f, rd_a, rd_z;
  logic        irq_m, irq_f, irq_a, irq_z;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  switch_pio_debounced #(.WIDTH(18), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_main (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_m), .readdata(rd_m), .irq(irq_m));
  switch_pio_debounced #(.WIDTH(18), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_f), .readdata(rd_f), .irq(irq_f));
  switch_pio_debounced #(.WIDTH(18), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a));
  switch_pio_debounced #(.WIDTH(18), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_nodb (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_z), .readdata(rd_z), .irq(irq_z));

  // Advance n rising edges; inputs change and outputs are sampled 1ns after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    step(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_m = 18'h3FFFF; in_f = '0; in_a = '0; in_z = '0;
    address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    step(2);
    checks++; if (rd_m !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected %h", rd_m, 32'h0); end
    checks++; if (irq_m !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq_m); end
    reset_n = 1'b1;
    step(6);
    checks++; if (rd_m !== 32'h0) begin errors++; $display("FAIL reset_data_early: got %h expected %h", rd_m, 32'h0); end
    step(1);
    checks++; if (rd_m !== 32'h3FFFF) begin errors++; $display("FAIL reset_data: got %h expected %h", rd_m, 32'h3FFFF); end
    address = 2'd1; step(1);
    checks++; if (rd_m !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h expected %h", rd_m, 32'h0); end
    address = 2'd3; step(1);
    checks++; if (rd_m !== 32'h3FFFF) begin errors++; $display("FAIL reset_edgecap: got %h expected %h", rd_m, 32'h3FFFF); end
    in_m = '0; step(10);
    wr(2'd3, 32'hFFFF_FFFF); step(1);
    checks++; if (rd_m !== 32'h0) begin errors++; $display("FAIL w1c_all: got %h expected %h", rd_m, 32'h0); end
  endtask

  task automatic test_regs;
    wr(2'd2, 32'hFFFF_FFFF); address = 2'd2; step(1);
    checks++; if (rd_m !== 32'h3FFFF) begin errors++; $display("FAIL irqmask_width: got %h expected %h", rd_m, 32'h3FFFF); end
    address = 2'd2; writedata = '0; write_n = 1'b0; chipselect = 1'b0; step(1);
    write_n = 1'b1; step(1);
    checks++; if (rd_m !== 32'h3FFFF) begin errors++; $display("FAIL no_cs_write: got %h expected %h", rd_m, 32'h3FFFF); end
    wr(2'd1, 32'hFFFF_FFFF); address = 2'd1; step(1);
    checks++; if (rd_m !== 32'h0) begin errors++; $display("FAIL reserved_write: got %h expected %h", rd_m, 32'h0); end
    checks++; if (irq_m !== 1'b0) begin errors++; $display("FAIL irq_no_capture: got %b expected 0", irq_m); end
    wr(2'd2, 32'h0);
  endtask

  task automatic test_glitch;
    address = 2'd0; in_m = 18'h1; step(3);
    in_m = '0; step(10);
    checks++; if (rd_m !== 32'h0) begin errors++; $display("FAIL glitch_data: got %h expected %h", rd_m, 32'h0); end
    address = 2'd3; step(1);
    checks++; if (rd_m !== 32'h0) begin errors++; $display("FAIL glitch_edgecap: got %h expected %h", rd_m, 32'h0); end
  endtask

  task automatic test_debounce_irq;
    wr(2'd2, 32'h1);
    address = 2'd0; in_m = 18'h1; step(6);
    checks++; if (rd_m !== 32'h0) begin errors++; $display("FAIL db_data_early: got %h expected %h", rd_m, 32'h0); end
    step(1);
    checks++; if (rd_m !== 32'h1) begin errors++; $display("FAIL db_data: got %h expected %h", rd_m, 32'h1); end
    checks++; if (irq_m !== 1'b0) begin errors++; $display("FAIL db_irq_early: got %b expected 0", irq_m); end
    address = 2'd3; step(1);
    checks++; if (rd_m !== 32'h1) begin errors++; $display("FAIL db_edgecap: got %h expected %h", rd_m, 32'h1); end
    checks++; if (irq_m !== 1'b1) begin errors++; $display("FAIL db_irq: got %b expected 1", irq_m); end
    wr(2'd3, 32'h1);
    checks++; if (irq_m !== 1'b1) begin errors++; $display("FAIL clr_irq_hold: got %b expected 1", irq_m); end
    step(1);
    checks++; if (irq_m !== 1'b0) begin errors++; $display("FAIL clr_irq_drop: got %b expected 0", irq_m); end
    checks++; if (rd_m !== 32'h0) begin errors++; $display("FAIL clr_edgecap: got %h expected %h", rd_m, 32'h0); end
  endtask

  task automatic test_w1c_race;
    in_m = 18'h21; step(6);
    wr(2'd3, 32'h20); step(1);
    checks++; if (rd_m !== 32'h20) begin errors++; $display("FAIL race_set_wins: got %h expected %h", rd_m, 32'h20); end
    checks++; if (irq_m !== 1'b0) begin errors++; $display("FAIL race_irq_masked: got %b expected 0", irq_m); end
    wr(2'd3, 32'h20); step(1);
    checks++; if (rd_m !== 32'h0) begin errors++; $display("FAIL race_clear: got %h expected %h", rd_m, 32'h0); end
  endtask

  task automatic test_mask;
    wr(2'd2, 32'h0);
    in_m = 18'h29; step(9);
    checks++; if (irq_m !== 1'b0) begin errors++; $display("FAIL mask_irq_off: got %b expected 0", irq_m); end
    address = 2'd3; step(1);
    checks++; if (rd_m !== 32'h8) begin errors++; $display("FAIL mask_edgecap: got %h expected %h", rd_m, 32'h8); end
    wr(2'd2, 32'h8);
    checks++; if (irq_m !== 1'b0) begin errors++; $display("FAIL unmask_irq_early: got %b expected 0", irq_m); end
    step(1);
    checks++; if (irq_m !== 1'b1) begin errors++; $display("FAIL unmask_irq: got %b expected 1", irq_m); end
    wr(2'd2, 32'h0);
    checks++; if (irq_m !== 1'b1) begin errors++; $display("FAIL remask_irq_hold: got %b expected 1", irq_m); end
    step(1);
    checks++; if (irq_m !== 1'b0) begin errors++; $display("FAIL remask_irq_drop: got %b expected 0", irq_m); end
    wr(2'd3, 32'h8);
  endtask

  task automatic test_modes;
    in_f = 18'h4; in_a = 18'h4; step(10);
    address = 2'd3; step(1);
    checks++; if (rd_f !== 32'h0) begin errors++; $display("FAIL fall_ignores_rise: got %h expected %h", rd_f, 32'h0); end
    checks++; if (rd_a !== 32'h4) begin errors++; $display("FAIL any_rise: got %h expected %h", rd_a, 32'h4); end
    wr(2'd3, 32'h4);
    in_f = '0; in_a = '0; step(10);
    checks++; if (rd_f !== 32'h4) begin errors++; $display("FAIL fall_capture: got %h expected %h", rd_f, 32'h4); end
    checks++; if (rd_a !== 32'h4) begin errors++; $display("FAIL any_fall: got %h expected %h", rd_a, 32'h4); end
    address = 2'd0; in_z = 18'h2A5A5; step(3);
    checks++; if (rd_z !== 32'h0) begin errors++; $display("FAIL nodb_early: got %h expected %h", rd_z, 32'h0); end
    step(1);
    checks++; if (rd_z !== 32'h2A5A5) begin errors++; $display("FAIL nodb_data: got %h expected %h", rd_z, 32'h2A5A5); end
    in_z = 18'h15A5A; step(4);
    checks++; if (rd_z !== 32'h15A5A) begin errors++; $display("FAIL nodb_data2: got %h expected %h", rd_z, 32'h15A5A); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_glitch();
    test_debounce_irq();
    test_w1c_race();
    test_mask();
    test_modes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
